// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider helper and default
// line parameters. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned C_DEF_SYSTEM_CLK = 50_000_000;
  localparam int unsigned C_DEF_BAUDRATE   = 9600;
  localparam int unsigned C_DEF_DATAWIDTH  = 8;
  localparam int unsigned C_DEF_STOPWIDTH  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned f_baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts while enabled and ticks for one cycle when the
// count reaches a programmable terminal value, then restarts from zero.
module uart_bit_timer #(
  parameter int unsigned P_CNT_W = 13
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [P_CNT_W-1:0] i_term,
  output logic               o_tick
);

  logic [P_CNT_W-1:0] cnt_q;
  logic [P_CNT_W-1:0] cnt_d;

  // Next count: restart on clear or on reaching the terminal count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    o_tick = i_en && (cnt_q == i_term);
    if (i_clr || o_tick) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge.
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the RX pin, detects start edges, samples each
// bit at its mid-point and presents the received word as a one-cycle pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK     = C_DEF_SYSTEM_CLK,
  parameter int unsigned P_UART_BUADRATE  = C_DEF_BAUDRATE,
  parameter int unsigned P_UART_DATAWIDTH = C_DEF_DATAWIDTH,
  parameter int unsigned P_UART_STOPWIDTH = C_DEF_STOPWIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_uart_rx,
  output logic [P_UART_DATAWIDTH-1:0] o_user_rx_data,
  output logic                        o_user_rx_valid,
  output logic                        o_frame_err,
  output logic                        o_rx_busy
);

  localparam int unsigned L_DIV   = f_baud_div(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam int unsigned L_HALF  = L_DIV / 2;
  localparam int unsigned L_CNT_W = $clog2(L_DIV);
  localparam int unsigned L_IDX_W = $clog2(P_UART_DATAWIDTH);

  localparam logic [L_CNT_W-1:0] L_TERM_FULL = L_CNT_W'(L_DIV - 1);
  localparam logic [L_CNT_W-1:0] L_TERM_HALF = L_CNT_W'(L_HALF - 1);
  localparam logic [L_IDX_W-1:0] L_IDX_LAST  = L_IDX_W'(P_UART_DATAWIDTH - 1);
  localparam logic               L_STOP_LAST = 1'(P_UART_STOPWIDTH - 1);

  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;
  logic rx_fall;

  uart_state_e                 state_q, state_d;
  logic [P_UART_DATAWIDTH-1:0] shift_q, shift_d;
  logic [L_IDX_W-1:0]          idx_q, idx_d;
  logic                        stop_q, stop_d;
  logic [P_UART_DATAWIDTH-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  logic               tmr_en;
  logic               tmr_clr;
  logic [L_CNT_W-1:0] tmr_term;
  logic               tmr_tick;

  uart_bit_timer #(
    .P_CNT_W (L_CNT_W)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (tmr_en),
    .i_clr  (tmr_clr),
    .i_term (tmr_term),
    .o_tick (tmr_tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // reset to the idle-high line level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // Next-state, datapath and timer control for the frame FSM.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    tmr_en   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_term = L_TERM_FULL;

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          tmr_clr = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tmr_en   = 1'b1;
        tmr_term = L_TERM_HALF;
        if (tmr_tick) begin
          if (!rx_s_q) begin
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        tmr_en = 1'b1;
        if (tmr_tick) begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 1'b1;
          if (idx_q == L_IDX_LAST) begin
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        tmr_en = 1'b1;
        if (tmr_tick) begin
          if (!rx_s_q) begin
            err_d   = 1'b1;
            state_d = ST_BREAK;
          end else if (stop_q == L_STOP_LAST) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Shift register holding the word being assembled.
  always_ff @(posedge i_clk) begin
    // NOTE: no reset here; every bit is rewritten before the word is ever
    // copied to the output, so a reset value would be dead logic.
    shift_q <= shift_d;
  end

  assign o_user_rx_data  = data_q;
  assign o_user_rx_valid = valid_q;
  assign o_frame_err     = err_q;
  assign o_rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bit-accurate line driver sends frames and
// a monitor collects every valid/error pulse; each scenario compares the
// collected words against the bytes it sent.
module tb_uart_rx;

  localparam int unsigned SYS_CLK = 480_000;
  localparam int unsigned BAUD    = 9600;
  localparam int          L_DIV   = 50;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic [7:0] o_user_rx_data;
  logic       o_user_rx_valid;
  logic       o_frame_err;
  logic       o_rx_busy;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  int   overlap_cnt = 0;
  logic [7:0] rx_q[$];

  uart_rx #(
    .P_SYSTEM_CLK     (SYS_CLK),
    .P_UART_BUADRATE  (BAUD),
    .P_UART_DATAWIDTH (8),
    .P_UART_STOPWIDTH (1)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_uart_rx       (i_uart_rx),
    .o_user_rx_data  (o_user_rx_data),
    .o_user_rx_valid (o_user_rx_valid),
    .o_frame_err     (o_frame_err),
    .o_rx_busy       (o_rx_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: collect words and error pulses away from the active edge.
  always @(negedge i_clk) begin
    if (o_user_rx_valid) rx_q.push_back(o_user_rx_data);
    if (o_frame_err) err_cnt = err_cnt + 1;
    if (o_user_rx_valid && o_frame_err) overlap_cnt = overlap_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d want <200000", cyc);
    $fatal(1, "watchdog");
  end

  // Hold the line at v for n bit-clock cycles; called and returns at posedge+1.
  task automatic line_hold(input logic v, input int n);
    i_uart_rx = v;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One frame: start bit, 8 data bits LSB first, one stop bit of value stop_val.
  task automatic drive_frame(input logic [7:0] b, input int bit_cyc, input logic stop_val);
    line_hold(1'b0, bit_cyc);
    for (int i = 0; i < 8; i++) line_hold(b[i], bit_cyc);
    line_hold(stop_val, bit_cyc);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_user_rx_valid, o_frame_err, o_rx_busy, o_user_rx_data} !== 11'd0)
      $display("FAIL reset_outputs: got valid=%b err=%b busy=%b data=%h want all 0",
               o_user_rx_valid, o_frame_err, o_rx_busy, o_user_rx_data);
    else n_pass++;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    line_hold(1'b1, 20);
    n_checks++;
    if (o_rx_busy !== 1'b0 || rx_q.size() != 0)
      $display("FAIL idle_after_reset: got busy=%b words=%0d want busy=0 words=0",
               o_rx_busy, rx_q.size());
    else n_pass++;
  endtask

  task automatic test_single();
    int   t0;
    int   lat = -1;
    bit   seen = 0;
    logic busy_mid = 1'b0;
    logic busy_at = 1'b1;
    int   err0 = err_cnt;
    rx_q.delete();
    t0 = cyc;
    fork
      drive_frame(8'hA5, L_DIV, 1'b1);
      begin
        repeat (100) @(negedge i_clk);
        busy_mid = o_rx_busy;
        for (int i = 0; i < 600 && !seen; i++) begin
          @(negedge i_clk);
          if (o_user_rx_valid) begin
            seen = 1;
            lat = cyc - t0;
            busy_at = o_rx_busy;
          end
        end
      end
    join
    line_hold(1'b1, 10);
    n_checks++;
    if (!seen) $display("FAIL single_timeout: no valid pulse within 700 cycles");
    else n_pass++;
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5)
      $display("FAIL single_data: got %0d words first=%h want 1 word a5",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else n_pass++;
    n_checks++;
    if (lat < 476 || lat > 480)
      $display("FAIL single_latency: got %0d cycles want 476..480", lat);
    else n_pass++;
    n_checks++;
    if (busy_mid !== 1'b1 || busy_at !== 1'b0)
      $display("FAIL single_busy: got mid=%b at_valid=%b want mid=1 at_valid=0",
               busy_mid, busy_at);
    else n_pass++;
    n_checks++;
    if (err_cnt != err0) $display("FAIL single_err: got %0d err pulses want 0", err_cnt - err0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h55};
    rx_q.delete();
    foreach (exp_q[i]) drive_frame(exp_q[i], L_DIV, 1'b1);
    line_hold(1'b1, 20);
    n_checks++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d words want %0d", rx_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int   err0 = err_cnt;
    logic busy_in = 1'b0;
    rx_q.delete();
    fork
      line_hold(1'b0, 15);
      begin
        repeat (10) @(negedge i_clk);
        busy_in = o_rx_busy;
      end
    join
    line_hold(1'b1, 100);
    n_checks++;
    if (busy_in !== 1'b1) $display("FAIL glitch_detect: got busy=%b during glitch want 1", busy_in);
    else n_pass++;
    n_checks++;
    if (rx_q.size() != 0 || err_cnt != err0 || o_rx_busy !== 1'b0)
      $display("FAIL glitch_reject: got words=%0d errs=%0d busy=%b want 0 0 0",
               rx_q.size(), err_cnt - err0, o_rx_busy);
    else n_pass++;
  endtask

  task automatic test_frame_err(input logic [7:0] prev_good);
    int err0 = err_cnt;
    rx_q.delete();
    drive_frame(8'h3C, L_DIV, 1'b0);
    line_hold(1'b1, 60);
    n_checks++;
    if (err_cnt - err0 != 1 || rx_q.size() != 0)
      $display("FAIL ferr_pulse: got errs=%0d words=%0d want 1 0", err_cnt - err0, rx_q.size());
    else n_pass++;
    n_checks++;
    if (o_user_rx_data !== prev_good || o_rx_busy !== 1'b0)
      $display("FAIL ferr_hold: got data=%h busy=%b want %h 0", o_user_rx_data, o_rx_busy, prev_good);
    else n_pass++;
    drive_frame(8'h81, L_DIV, 1'b1);
    line_hold(1'b1, 20);
    n_checks++;
    if (rx_q.size() != 1 || o_user_rx_data !== 8'h81 || err_cnt - err0 != 1)
      $display("FAIL ferr_recover: got words=%0d data=%h errs=%0d want 1 81 1",
               rx_q.size(), o_user_rx_data, err_cnt - err0);
    else n_pass++;
  endtask

  task automatic test_baud_skew();
    rx_q.delete();
    drive_frame(8'h96, L_DIV + 1, 1'b1);
    line_hold(1'b1, 30);
    drive_frame(8'h69, L_DIV - 1, 1'b1);
    line_hold(1'b1, 30);
    n_checks++;
    if (rx_q.size() != 2) $display("FAIL skew_count: got %0d words want 2", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 2) begin
      n_checks++;
      if (rx_q[0] !== 8'h96 || rx_q[1] !== 8'h69)
        $display("FAIL skew_data: got %h %h want 96 69", rx_q[0], rx_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic [11:0] after_rst = 12'hfff;
    int err0 = err_cnt;
    b = 8'hF0 | 8'($urandom_range(0, 15));
    rx_q.delete();
    fork
      drive_frame(b, L_DIV, 1'b1);
      begin
        repeat (270) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        after_rst = {o_user_rx_valid, o_frame_err, o_rx_busy, o_user_rx_data, 1'b0};
      end
    join
    line_hold(1'b1, 40);
    n_checks++;
    if (after_rst !== 12'd0) $display("FAIL rst_outputs: got %h want 000", after_rst);
    else n_pass++;
    n_checks++;
    if (rx_q.size() != 0 || err_cnt != err0 || o_user_rx_data !== 8'h00)
      $display("FAIL rst_abandon: got words=%0d errs=%0d data=%h want 0 0 00",
               rx_q.size(), err_cnt - err0, o_user_rx_data);
    else n_pass++;
    drive_frame(8'h42, L_DIV, 1'b1);
    line_hold(1'b1, 20);
    n_checks++;
    if (rx_q.size() != 1 || o_user_rx_data !== 8'h42)
      $display("FAIL rst_recover: got words=%0d data=%h want 1 42", rx_q.size(), o_user_rx_data);
    else n_pass++;
  endtask

  // Random frames with random skew, gaps and occasional bad stop bits,
  // checked against a list of expected words and error count.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] last_good = o_user_rx_data;
    int exp_err = 0;
    int err0 = err_cnt;
    rx_q.delete();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      int per;
      bit bad;
      b = 8'($urandom);
      per = L_DIV - 1 + int'($urandom_range(0, 2));
      bad = ($urandom_range(0, 5) == 0);
      drive_frame(b, per, !bad);
      if (bad) begin
        exp_err++;
        line_hold(1'b1, 60 + int'($urandom_range(0, 20)));
      end else begin
        exp_q.push_back(b);
        last_good = b;
        if ($urandom_range(0, 1) == 1) line_hold(1'b1, int'($urandom_range(1, 40)));
      end
    end
    line_hold(1'b1, 20);
    n_checks++;
    if (rx_q.size() != exp_q.size() || err_cnt - err0 != exp_err)
      $display("FAIL rand_counts: got words=%0d errs=%0d want %0d %0d",
               rx_q.size(), err_cnt - err0, exp_q.size(), exp_err);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (o_user_rx_data !== last_good)
      $display("FAIL rand_hold: got data=%h want %h", o_user_rx_data, last_good);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err(8'h55);
    test_baud_skew();
    test_reset_mid_frame();
    test_random();
    n_checks++;
    if (overlap_cnt != 0)
      $display("FAIL valid_err_overlap: got %0d cycles with both high want 0", overlap_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
